// File: rtl/qsfp_pkg.sv
// Shared definitions for the QSFP cage pin sequencer: cage count, state encoding,
// insertion-count width and a small helper for sizing the per-cage timer.
package qsfp_pkg;

  localparam int unsigned QSFP_CAGES = 2;
  localparam int unsigned INS_CNT_W  = 8;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    StAbsent   = 3'd0,
    StDebounce = 3'd1,
    StReset    = 3'd2,
    StInit     = 3'd3,
    StReady    = 3'd4
  } qsfp_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qsfp_pin_seq_if.sv
// Register-side controls and cage-pin outputs for all QSFP cages, bundled as one interface.
interface qsfp_pin_seq_if
  import qsfp_pkg::*;
;
  logic [QSFP_CAGES-1:0]           present_l;
  logic [QSFP_CAGES-1:0]           sw_rst;
  logic [QSFP_CAGES-1:0]           sw_lp;
  logic [QSFP_CAGES-1:0]           pin_rst_l;
  logic [QSFP_CAGES-1:0]           pin_lp;
  logic [QSFP_CAGES-1:0]           ready;
  logic [QSFP_CAGES*STATE_W-1:0]   state;
  logic [QSFP_CAGES*INS_CNT_W-1:0] insert_count;

  modport master (
    output present_l, sw_rst, sw_lp,
    input  pin_rst_l, pin_lp, ready, state, insert_count
  );

  modport slave (
    input  present_l, sw_rst, sw_lp,
    output pin_rst_l, pin_lp, ready, state, insert_count
  );
endinterface

// File: rtl/qsfp_cage_seq.sv
// One cage's power-up sequencer: debounce, reset hold, init wait, ready,
// with a single shared down-counter and a saturating insertion count.
module qsfp_cage_seq
  import qsfp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
  parameter int unsigned RST_HOLD_CYCLES  = 2500,
  parameter int unsigned INIT_WAIT_CYCLES = 500000000,
  parameter int unsigned CntW             = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 present_l,
  input  logic                 sw_rst,
  input  logic                 sw_lp,
  output logic                 pin_rst_l,
  output logic                 pin_lp,
  output logic                 ready,
  output logic [STATE_W-1:0]   state,
  output logic [INS_CNT_W-1:0] insert_count
);

  localparam logic [CntW-1:0] DebLoad  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] RstLoad  = CntW'(RST_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] InitLoad = CntW'(INIT_WAIT_CYCLES - 1);

  qsfp_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_dec;
  logic [INS_CNT_W-1:0] ins_q, ins_d;
  logic                 pin_rst_l_q, pin_rst_l_d;
  logic                 pin_lp_q, pin_lp_d;
  logic                 ready_q, ready_d;
  logic                 expired;

  assign expired = (cnt_q == '0);
  // Parks at zero so a held sw_rst keeps RESET sitting at expiry.
  assign cnt_dec = expired ? cnt_q : cnt_q - 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_dec;
    ins_d   = ins_q;
    if (state_q != StAbsent && present_l) begin
      state_d = StAbsent;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StAbsent: begin
          cnt_d = '0;
          if (!present_l) begin
            state_d = StDebounce;
            cnt_d   = DebLoad;
          end
        end
        StDebounce: begin
          if (expired) begin
            state_d = StReset;
            cnt_d   = RstLoad;
            ins_d   = (ins_q == '1) ? ins_q : ins_q + 1'b1;
          end
        end
        StReset: begin
          if (expired && !sw_rst) begin
            state_d = StInit;
            cnt_d   = InitLoad;
          end
        end
        StInit: begin
          if (sw_rst) begin
            state_d = StReset;
            cnt_d   = RstLoad;
          end else if (expired) begin
            state_d = StReady;
          end
        end
        StReady: begin
          if (sw_rst) begin
            state_d = StReset;
            cnt_d   = RstLoad;
          end
        end
        default: begin
          state_d = StAbsent;
          cnt_d   = '0;
        end
      endcase
    end

    // Pin values follow the state being entered so they change together with it.
    pin_rst_l_d = (state_d == StInit) || (state_d == StReady);
    pin_lp_d    = pin_rst_l_d ? sw_lp : 1'b1;
    ready_d     = (state_d == StReady);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StAbsent;
      cnt_q       <= '0;
      ins_q       <= '0;
      pin_rst_l_q <= 1'b0;
      pin_lp_q    <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ins_q       <= ins_d;
      pin_rst_l_q <= pin_rst_l_d;
      pin_lp_q    <= pin_lp_d;
      ready_q     <= ready_d;
    end
  end

  assign pin_rst_l    = pin_rst_l_q;
  assign pin_lp       = pin_lp_q;
  assign ready        = ready_q;
  assign state        = state_q;
  assign insert_count = ins_q;

endmodule

// File: rtl/qsfp_pin_seq.sv
// QSFP cage power-up/reset sequencer: one independent qsfp_cage_seq per cage,
// with per-cage results packed onto the shared interface.
module qsfp_pin_seq
  import qsfp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
  parameter int unsigned RST_HOLD_CYCLES  = 2500,
  parameter int unsigned INIT_WAIT_CYCLES = 500000000
) (
  input logic            clk,
  input logic            reset,
  qsfp_pin_seq_if.slave  bus
);

  localparam int unsigned CntW =
      $clog2(max3(DEBOUNCE_CYCLES, RST_HOLD_CYCLES, INIT_WAIT_CYCLES)) + 1;

  logic                 pin_rst_l_c [QSFP_CAGES];
  logic                 pin_lp_c    [QSFP_CAGES];
  logic                 ready_c     [QSFP_CAGES];
  logic [STATE_W-1:0]   state_c     [QSFP_CAGES];
  logic [INS_CNT_W-1:0] ins_c       [QSFP_CAGES];

  for (genvar g = 0; g < QSFP_CAGES; g++) begin : g_cage
    qsfp_cage_seq #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .RST_HOLD_CYCLES  (RST_HOLD_CYCLES),
      .INIT_WAIT_CYCLES (INIT_WAIT_CYCLES),
      .CntW             (CntW)
    ) u_cage (
      .clk          (clk),
      .reset        (reset),
      .present_l    (bus.present_l[g]),
      .sw_rst       (bus.sw_rst[g]),
      .sw_lp        (bus.sw_lp[g]),
      .pin_rst_l    (pin_rst_l_c[g]),
      .pin_lp       (pin_lp_c[g]),
      .ready        (ready_c[g]),
      .state        (state_c[g]),
      .insert_count (ins_c[g])
    );
  end

  always_comb begin
    bus.pin_rst_l    = '0;
    bus.pin_lp       = '0;
    bus.ready        = '0;
    bus.state        = '0;
    bus.insert_count = '0;
    for (int i = 0; i < QSFP_CAGES; i++) begin
      bus.pin_rst_l[i]                          = pin_rst_l_c[i];
      bus.pin_lp[i]                             = pin_lp_c[i];
      bus.ready[i]                              = ready_c[i];
      bus.state[i*STATE_W +: STATE_W]           = state_c[i];
      bus.insert_count[i*INS_CNT_W +: INS_CNT_W] = ins_c[i];
    end
  end

endmodule

// File: tb/tb_qsfp_pin_seq.sv
// Scoreboard bench for qsfp_pin_seq: directed test-plan sequences plus random traffic,
// checked every cycle against a phase/elapsed-time reference model.
module tb_qsfp_pin_seq;

  localparam int unsigned D = 4;
  localparam int unsigned R = 3;
  localparam int unsigned I = 5;

  typedef struct packed {
    logic [5:0]  st;
    logic [1:0]  rst_l;
    logic [1:0]  lp;
    logic [1:0]  rdy;
    logic [15:0] ic;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  qsfp_pin_seq_if bus ();

  qsfp_pin_seq #(
    .DEBOUNCE_CYCLES  (D),
    .RST_HOLD_CYCLES  (R),
    .INIT_WAIT_CYCLES (I)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic       r_in;
  logic [1:0] pl_in, sr_in, lp_in;
  int         m_ph [2];
  int         m_el [2];
  int         m_ins [2];
  obs_t       sb_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  // Reference: phases 0..4 = absent, debounce, reset, init, ready; m_el counts cycles spent.
  task automatic model_step();
    obs_t e;
    for (int c = 0; c < 2; c++) begin
      if (r_in) begin
        m_ph[c] = 0; m_el[c] = 0; m_ins[c] = 0;
      end else if (pl_in[c]) begin
        m_ph[c] = 0; m_el[c] = 0;
      end else begin
        case (m_ph[c])
          0: begin m_ph[c] = 1; m_el[c] = 1; end
          1: if (m_el[c] >= D) begin
               m_ph[c] = 2; m_el[c] = 1;
               if (m_ins[c] < 255) m_ins[c]++;
             end else m_el[c]++;
          2: if (m_el[c] >= R && !sr_in[c]) begin m_ph[c] = 3; m_el[c] = 1; end
             else m_el[c]++;
          3: if (sr_in[c]) begin m_ph[c] = 2; m_el[c] = 1; end
             else if (m_el[c] >= I) begin m_ph[c] = 4; m_el[c] = 1; end
             else m_el[c]++;
          default: if (sr_in[c]) begin m_ph[c] = 2; m_el[c] = 1; end
        endcase
      end
      e.st[3*c +: 3]  = 3'(m_ph[c]);
      e.rst_l[c]      = (m_ph[c] >= 3);
      e.lp[c]         = (m_ph[c] >= 3) ? lp_in[c] : 1'b1;
      e.rdy[c]        = (m_ph[c] == 4);
      e.ic[8*c +: 8]  = 8'(m_ins[c]);
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset         = r_in;
      bus.present_l = pl_in;
      bus.sw_rst    = sr_in;
      bus.sw_lp     = lp_in;
      model_step();
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per edge.
  always begin
    obs_t e, a;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      a = {bus.state, bus.pin_rst_l, bus.pin_lp, bus.ready, bus.insert_count};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got st=%h rl=%b lp=%b rdy=%b ic=%h want st=%h rl=%b lp=%b rdy=%b ic=%h",
                 $time, a.st, a.rst_l, a.lp, a.rdy, a.ic, e.st, e.rst_l, e.lp, e.rdy, e.ic);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    r_in = 1'b1; pl_in = 2'b11; sr_in = 2'b00; lp_in = 2'b00;
    reset = 1'b1; bus.present_l = 2'b11; bus.sw_rst = 2'b00; bus.sw_lp = 2'b00;
    step(3);
    r_in = 1'b0;
    step(7);

    // Basic insertion on cage 0
    pl_in[0] = 1'b0;
    step(20);

    // Bounce: short low pulses never reach RESET
    pl_in[0] = 1'b1;
    step(2);
    for (int b = 0; b < 3; b++) begin
      pl_in[0] = 1'b0; step(2);
      pl_in[0] = 1'b1; step(2);
    end

    // Both cages to READY, then low-power toggles and software reset
    pl_in = 2'b00;
    step(D + R + I + 3);
    for (int t = 0; t < 4; t++) begin lp_in[1] = ~lp_in[1]; step(1); end
    sr_in[0] = 1'b1; step(10);
    sr_in[0] = 1'b0; step(8);
    sr_in[1] = 1'b1; step(2);
    for (int t = 0; t < 4; t++) begin lp_in[1] = ~lp_in[1]; step(1); end
    sr_in[1] = 1'b0; step(2);
    pl_in[1] = 1'b1; step(3);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 19) == 0) pl_in[c] = ~pl_in[c];
        sr_in[c] = ($urandom_range(0, 11) == 0) ? 1'b1 : (sr_in[c] && $urandom_range(0, 2) != 0);
        lp_in[c] = 1'($urandom_range(0, 1));
      end
      r_in = ($urandom_range(0, 299) == 0);
      step(1);
    end

    // Saturation: 260 complete insertions on cage 0
    r_in = 1'b0; pl_in = 2'b11; sr_in = 2'b00; lp_in = 2'b00;
    step(2);
    for (int k = 0; k < 260; k++) begin
      pl_in[0] = 1'b0; step(D + 1);
      pl_in[0] = 1'b1; step(1);
    end
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (bus.insert_count[7:0] !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation got %0d want 255", bus.insert_count[7:0]);
    end

    // Reset asserted while cage 0 is in INIT
    pl_in[0] = 1'b0; step(D + R + 2);
    r_in = 1'b1; step(1);
    r_in = 1'b0; pl_in[0] = 1'b1; step(3);

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
